// File: rtl/spi_slave_xfer_ctrl_pkg.sv
// Shared types and sizing helpers for the SPI slave transfer controller.
package spi_slave_ctrl_pkg;

    typedef enum logic {IDLE, ACTIVE} spi_slave_state_e;

    // Bit counter must hold the value DATA_WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/spi_slave_xfer_ctrl_if.sv
// Local requester side of the SPI slave: TX word push and RX word pop handshakes.
interface spi_slave_xfer_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave_xfer_ctrl_sync2.sv
// Two-flop synchronizer of configurable width; resets to all zeros.
module spi_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             pclk,
    input  logic             areset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/spi_slave_xfer_ctrl.sv
// SPI slave transfer controller (all CPOL/CPHA modes, MSB/LSB first).
// Optional sticky error flags: define SPI_SLAVE_ERR_FLAGS_EN.
module spi_slave_xfer_ctrl
    import spi_slave_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic                  cfg_msb_first,
    input  logic                  sclk_i,
    input  logic                  cs_n_i,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic                  busy_o,
    output logic                  underrun_o,
    output logic                  overrun_o,
    input  logic                  err_clr,
    spi_slave_xfer_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [2:0] pins_s;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d, cpol_q;
    logic lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;

    spi_slave_state_e state_q, state_d;
    logic load_tx, do_sample, do_shift, cs_exit, word_done, ur_evt, ov_evt;

    logic [DATA_WIDTH-1:0] hold_data, tx_sh, rx_sh, rx_next;
    logic                  hold_full;
    logic [CNT_W-1:0]      bit_cnt;

    spi_sync2 #(.WIDTH(3)) u_sync (
        .pclk   (pclk),
        .areset (areset),
        .d      ({sclk_i, cs_n_i, mosi_i}),
        .q      (pins_s)
    );

    assign sclk_s = pins_s[2];
    assign cs_s   = pins_s[1];
    assign mosi_s = pins_s[0];

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            sclk_d <= 1'b0;
            cs_d   <= 1'b0;
            cpol_q <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            if (state_q == IDLE) cpol_q <= cfg_cpol;
        end
    end

    assign lead_edge   = (sclk_s != sclk_d) && (sclk_d == cpol_q);
    assign trail_edge  = (sclk_s != sclk_d) && (sclk_s == cpol_q);
    assign sample_edge = cfg_cpha ? trail_edge : lead_edge;
    assign shift_edge  = cfg_cpha ? lead_edge  : trail_edge;
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // A shift edge with the bit count at 0 follows a (re)load: the first bit is
    // already on MISO, so it must not advance (cpha=1 entry, cpha=0 word boundary).
    always_comb begin
        state_d   = state_q;
        load_tx   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        cs_exit   = 1'b0;
        busy_o    = 1'b0;
        miso_oe_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load_tx = 1'b1;
                end
            end
            ACTIVE: begin
                busy_o    = 1'b1;
                miso_oe_o = 1'b1;
                if (cs_rise) begin
                    state_d = IDLE;
                    cs_exit = 1'b1;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge && (bit_cnt != '0);
                end
            end
            default: state_d = IDLE;
        endcase
        word_done = do_sample && (bit_cnt == LAST_BIT);
        if (word_done) load_tx = 1'b1;
    end

    assign rx_next = cfg_msb_first ? {rx_sh[DATA_WIDTH-2:0], mosi_s}
                                   : {mosi_s, rx_sh[DATA_WIDTH-1:1]};
    assign miso_o  = (state_q == ACTIVE) &&
                     (cfg_msb_first ? tx_sh[DATA_WIDTH-1] : tx_sh[0]);
    assign bus.tx_ready = ~hold_full;
    assign ur_evt = load_tx && !hold_full;
    assign ov_evt = word_done && bus.rx_valid && !bus.rx_ready;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            hold_data    <= '0;
            hold_full    <= 1'b0;
            tx_sh        <= '0;
            rx_sh        <= '0;
            bit_cnt      <= '0;
            bus.rx_data  <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            if (load_tx && hold_full) begin
                hold_full <= 1'b0;
            end else if (bus.tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= bus.tx_data;
            end

            if (load_tx)
                tx_sh <= hold_full ? hold_data : '0;
            else if (do_shift)
                tx_sh <= cfg_msb_first ? {tx_sh[DATA_WIDTH-2:0], 1'b0}
                                       : {1'b0, tx_sh[DATA_WIDTH-1:1]};

            if (do_sample) rx_sh <= rx_next;

            if (cs_exit || word_done) bit_cnt <= '0;
            else if (do_sample)       bit_cnt <= bit_cnt + CNT_W'(1);

            if (word_done) begin
                bus.rx_data  <= rx_next;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end
        end
    end

`ifdef SPI_SLAVE_ERR_FLAGS_EN
    logic underrun_q, overrun_q;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (ur_evt)       underrun_q <= 1'b1;
            else if (err_clr) underrun_q <= 1'b0;
            if (ov_evt)       overrun_q  <= 1'b1;
            else if (err_clr) overrun_q  <= 1'b0;
        end
    end

    assign underrun_o = underrun_q;
    assign overrun_o  = overrun_q;
`else
    logic unused_err_sig;
    assign unused_err_sig = err_clr ^ ur_evt ^ ov_evt;
    assign underrun_o = 1'b0;
    assign overrun_o  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_xfer_ctrl.sv
// Self-checking bench for spi_slave_xfer_ctrl: bit-banged SPI master plus a word-level reference model.
module tb_spi_slave_xfer_ctrl;
    localparam int DW = 8;
    localparam int H  = 8;
`ifdef SPI_SLAVE_ERR_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic pclk = 1'b0;
    logic areset, cfg_cpol, cfg_cpha, cfg_msb_first;
    logic sclk_i, cs_n_i, mosi_i, err_clr;
    logic miso_o, miso_oe_o, busy_o, underrun_o, overrun_o;

    spi_slave_xfer_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave_xfer_ctrl #(.DATA_WIDTH(DW)) u_dut (
        .pclk          (pclk),
        .areset        (areset),
        .cfg_cpol      (cfg_cpol),
        .cfg_cpha      (cfg_cpha),
        .cfg_msb_first (cfg_msb_first),
        .sclk_i        (sclk_i),
        .cs_n_i        (cs_n_i),
        .mosi_i        (mosi_i),
        .miso_o        (miso_o),
        .miso_oe_o     (miso_oe_o),
        .busy_o        (busy_o),
        .underrun_o    (underrun_o),
        .overrun_o     (overrun_o),
        .err_clr       (err_clr),
        .bus           (bus)
    );

    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int a0;

    // Reference model: word-level view of holding register, RX word and flags.
    logic [7:0] hold_q[$];
    logic [7:0] cur_tx;
    logic [7:0] m_rx;
    bit         m_pend, m_ur, m_ov, rdy_lvl;
    logic [7:0] got;

    always @(posedge pclk) if (bus.rx_valid && bus.rx_ready) acc_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge pclk);
    endtask

    function automatic logic [7:0] pop_tx();
        if (hold_q.size() > 0) return hold_q.pop_front();
        m_ur = 1'b1;
        return 8'h00;
    endfunction

    task automatic push_tx(input logic [7:0] w);
        int k;
        k = 0;
        while (bus.tx_ready !== 1'b1 && k < 200) begin
            cyc(1);
            k++;
        end
        chk("push_tx_ready", bus.tx_ready, 1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        cyc(1);
        bus.tx_valid = 1'b0;
        hold_q.push_back(w);
    endtask

    task automatic set_mode(input bit cpol, input bit cpha, input bit msb);
        cfg_cpol      = cpol;
        cfg_cpha      = cpha;
        cfg_msb_first = msb;
        sclk_i        = cpol;
        cyc(H);
    endtask

    task automatic cs_fall();
        cs_n_i = 1'b0;
        cur_tx = pop_tx();
        cyc(H);
        chk("miso_oe_selected", miso_oe_o, 1);
        chk("busy_selected", busy_o, 1);
    endtask

    task automatic cs_rise();
        cyc(H);
        cs_n_i = 1'b1;
        cyc(H);
        chk("busy_idle", busy_o, 0);
        chk("miso_oe_idle", miso_oe_o, 0);
    endtask

    // Master: drives MOSI on its shift edge, samples MISO just before its sample edge.
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        int idx;
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            idx = cfg_msb_first ? 7 - k : k;
            if (!cfg_cpha) begin
                mosi_i = mo[idx];
                cyc(H);
                mi[idx] = miso_o;
                sclk_i = ~cfg_cpol;
                cyc(H);
                sclk_i = cfg_cpol;
            end else begin
                sclk_i = ~cfg_cpol;
                mosi_i = mo[idx];
                cyc(H);
                mi[idx] = miso_o;
                sclk_i = cfg_cpol;
                cyc(H);
            end
        end
        cyc(H + 4);
        if (nbits == 8) begin
            if (m_pend && !rdy_lvl) m_ov = 1'b1;
            m_pend = !rdy_lvl;
            m_rx   = mo;
            cur_tx = pop_tx();
        end
    endtask

    task automatic frame_word(input logic [7:0] mo);
        logic [7:0] exp_tx, rcv;
        exp_tx = cur_tx;
        xfer(mo, 8, rcv);
        chk("miso_word", rcv, exp_tx);
        chk("rx_data", bus.rx_data, m_rx);
        chk("rx_valid", bus.rx_valid, m_pend);
        chk("underrun", underrun_o, FLAGS_EN & m_ur);
        chk("overrun", overrun_o, FLAGS_EN & m_ov);
    endtask

    task automatic accept_rx();
        bus.rx_ready = 1'b1;
        cyc(1);
        bus.rx_ready = rdy_lvl;
        m_pend = 1'b0;
        cyc(1);
        chk("rx_valid_after_accept", bus.rx_valid, 0);
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        m_ur = 1'b0;
        m_ov = 1'b0;
        cyc(1);
        chk("underrun_cleared", underrun_o, 0);
        chk("overrun_cleared", overrun_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_miso"}, miso_o, 0);
        chk({tag, "_miso_oe"}, miso_oe_o, 0);
        chk({tag, "_tx_ready"}, bus.tx_ready, 1);
        chk({tag, "_rx_valid"}, bus.rx_valid, 0);
        chk({tag, "_rx_data"}, bus.rx_data, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_underrun"}, underrun_o, 0);
        chk({tag, "_overrun"}, overrun_o, 0);
    endtask

    initial begin
        areset = 1'b0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_msb_first = 1'b1;
        sclk_i = 1'b0; cs_n_i = 1'b1; mosi_i = 1'b0; err_clr = 1'b0;
        bus.tx_data = '0; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
        rdy_lvl = 1'b0; m_pend = 1'b0; m_ur = 1'b0; m_ov = 1'b0; m_rx = 8'h00;
        cur_tx = 8'h00;
        cyc(3);
        check_reset_outputs("reset");
        areset = 1'b1;
        cyc(H);

        // Mode 0, MSB first: A5 out, 3C in
        set_mode(1'b0, 1'b0, 1'b1);
        push_tx(8'hA5);
        cs_fall();
        chk("mode0_first_bit", miso_o, 1);
        frame_word(8'h3C);
        cs_rise();
        accept_rx();

        // Modes 1..3, LSB first: 81 out, 7E in
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b0);
            push_tx(8'h81);
            cs_fall();
            frame_word(8'h7E);
            cs_rise();
            accept_rx();
        end

        // Back-to-back words, rx_ready held high
        clear_err();
        set_mode(1'b0, 1'b0, 1'b1);
        rdy_lvl = 1'b1;
        bus.rx_ready = 1'b1;
        cyc(2);
        a0 = acc_cnt;
        push_tx(8'h11);
        cs_fall();
        chk("b2b_tx_ready_load1", bus.tx_ready, 1);
        push_tx(8'h22);
        frame_word(8'($urandom));
        chk("b2b_tx_ready_load2", bus.tx_ready, 1);
        frame_word(8'($urandom));
        cs_rise();
        chk("b2b_accept_count", acc_cnt - a0, 2);
        rdy_lvl = 1'b0;
        bus.rx_ready = 1'b0;

        // Underrun: holding register empty at cs_n fall
        clear_err();
        set_mode(1'b1, 1'b1, 1'b1);
        cs_fall();
        chk("underrun_at_entry", underrun_o, FLAGS_EN);
        frame_word(8'($urandom));
        cs_rise();
        accept_rx();
        clear_err();

        // Overrun: two words with rx_ready low
        set_mode(1'b0, 1'b1, 1'b0);
        push_tx(8'($urandom));
        cs_fall();
        frame_word(8'hAA);
        frame_word(8'h55);
        cs_rise();
        chk("overrun_rx_data", bus.rx_data, 8'h55);
        accept_rx();
        clear_err();

        // Abort after 5 bits, then a full word
        set_mode(1'b0, 1'b0, 1'b1);
        push_tx(8'($urandom));
        cs_fall();
        xfer(8'($urandom), 5, got);
        cs_rise();
        chk("abort_no_rx_valid", bus.rx_valid, 0);
        push_tx(8'($urandom));
        cs_fall();
        frame_word(8'hC3);
        cs_rise();
        chk("after_abort_rx_data", bus.rx_data, 8'hC3);
        accept_rx();

        // Reset asserted mid-word
        set_mode(1'b1, 1'b0, 1'b1);
        push_tx(8'($urandom));
        cs_fall();
        xfer(8'($urandom), 3, got);
        areset = 1'b0;
        #1;
        check_reset_outputs("midword_reset");
        hold_q.delete();
        m_pend = 1'b0; m_ur = 1'b0; m_ov = 1'b0; m_rx = 8'h00;
        cyc(3);
        sclk_i = cfg_cpol;
        areset = 1'b1;
        cyc(2 * H);
        chk("reset_cs_low_stays_idle", busy_o, 0);
        cs_n_i = 1'b1;
        cyc(H);
        push_tx(8'($urandom));
        cs_fall();
        frame_word(8'($urandom));
        cs_rise();
        accept_rx();

        // Randomized frames
        for (int r = 0; r < 8; r++) begin
            set_mode(1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) push_tx(8'($urandom));
            cs_fall();
            frame_word(8'($urandom));
            if ($urandom_range(0, 1) == 1) frame_word(8'($urandom));
            cs_rise();
            accept_rx();
            if ($urandom_range(0, 1) == 1) clear_err();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/spi_slave_xfer_ctrl.md
# spi_slave_xfer_ctrl

Synthesizable SPI slave transfer controller that sequences the slave side of an SPI bus in the `pclk` domain. It oversamples `sclk`, `cs_n` and `mosi` and shifts words in and out according to the CPOL/CPHA mode. It also exchanges words with a local requester over valid/ready handshakes. It is the RTL counterpart that `slave_driver_bfm` stimulus is checked against in the HDL top.

## Interface

- `DATA_WIDTH`, 8: bits per SPI word (range 4..32).
- `pclk`, input, 1: system clock; all logic is on its rising edge.
- `areset`, input, 1: asynchronous, active-low reset.
- `cfg_cpol`, input, 1: `sclk` idle level. Quasi-static; sampled only in IDLE.
- `cfg_cpha`, input, 1: 0 = sample on leading edge, 1 = sample on trailing edge. Quasi-static.
- `cfg_msb_first`, input, 1: 1 = MSB shifted first. Quasi-static.
- `sclk_i`, input, 1: SPI clock pin.
- `cs_n_i`, input, 1: chip select pin, active-low.
- `mosi_i`, input, 1: master-out data pin.
- `miso_o`, output, 1: slave-out data.
- `miso_oe_o`, output, 1: MISO output enable; 1 while selected.
- `tx_data`, input, `DATA_WIDTH`: next word to transmit.
- `tx_valid`, input, 1: `tx_data` is valid.
- `tx_ready`, output, 1: TX holding register is empty.
- `rx_data`, output, `DATA_WIDTH`: last received word.
- `rx_valid`, output, 1: `rx_data` is valid; held until accepted.
- `rx_ready`, input, 1: requester accepts `rx_data`.
- `busy_o`, output, 1: controller is in ACTIVE.
- `underrun_o`, output, 1: sticky; a word started with the TX holding register empty.
- `overrun_o`, output, 1: sticky; a word completed while `rx_valid` was still high.
- `err_clr`, input, 1: pulse that clears both sticky flags.

## Operation

- **Synchronizers.** `sclk_i`, `cs_n_i` and `mosi_i` each pass through 2-flop synchronizers. Edges are detected on the synchronized `sclk` against a delayed copy.
  - Leading edge: a transition away from `cfg_cpol`. Trailing edge: a transition back to it.
  - Sample edge: the leading edge if `cfg_cpha`=0, otherwise the trailing edge. Shift edge: the other one.
- **TX holding register.** One entry. `tx_ready`=1 when empty. A `tx_valid & tx_ready` cycle loads it.
- **FSM IDLE.**
  - `miso_oe_o`=0, `busy_o`=0, bit count is 0.
  - On synchronized `cs_n` falling: load the shift register from the holding register (which then empties), or load all zeros and set underrun if it is empty. Go to ACTIVE.
- **FSM ACTIVE.**
  - `miso_o` shows the shift-register bit selected by `cfg_msb_first`.
  - Each sample edge captures synchronized `mosi` into the RX shift register and increments the bit count.
  - Each shift edge advances the TX shift register. The shift edge is ignored before the first sample when `cfg_cpha`=1, so that bit 0 is presented on the first leading edge.
  - When the bit count reaches `DATA_WIDTH`:
    - the RX word transfers to `rx_data` and `rx_valid` is set;
    - if `rx_valid` was already 1 and not accepted in that same cycle, set overrun; the data is overwritten;
    - the bit count returns to 0 and the TX shift register reloads as on entry (same underrun rule).
- **Exit from ACTIVE.** Synchronized `cs_n` rising returns the FSM to IDLE from any bit position.
  - A partial RX word is discarded.
  - A partial TX word is lost; the holding register is untouched.
- **RX handshake.** `rx_valid` clears on `rx_valid & rx_ready`. If completion and acceptance happen in the same cycle, the new word wins and `rx_valid` stays 1.
- **Error flags.** `err_clr` clears the flags. If a set event coincides with `err_clr`, the set wins.
- **Reset.** All state clears immediately. If `cs_n` is low when reset releases, the controller waits in IDLE until it sees a `cs_n` falling edge.

## Timing

- Reset values:
  - `miso_o`=0, `miso_oe_o`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0;
  - `busy_o`=0, `underrun_o`=0, `overrun_o`=0;
  - FSM in IDLE.
- Pin-to-detect latency: 3 `pclk` cycles (2 synchronizer flops plus 1 edge register).
- Requirements on `sclk`:
  - each high phase and each low phase lasts at least 4 `pclk` cycles;
  - the first sample edge comes at least 4 `pclk` after `cs_n` falls.
- `miso_o` updates 1 `pclk` after the detected shift edge, and 1 `pclk` after detected `cs_n` fall for the first bit.
- `rx_valid` rises 1 `pclk` after the detected final sample edge.
- `tx_ready` rises 1 `pclk` after a word load empties the holding register.
- When a load and a new `tx_valid` fall in the same cycle, the load takes the old word and the new word is refused (`tx_ready` was 0).

## Configuration

- Macro: `SPI_SLAVE_ERR_FLAGS_EN`.
- Defined: `underrun_o` and `overrun_o` are sticky flags as described, cleared by `err_clr`.
- Not defined: both outputs are tied to 0, `err_clr` is ignored and no flag flops are synthesized. Data behaviour is unchanged, including the overwrite on overrun.

## Structure

- Package `spi_slave_ctrl_pkg`:
  - `typedef enum logic {IDLE, ACTIVE} spi_slave_state_e`;
  - the bit-counter width constant, computed as `$clog2(DATA_WIDTH+1)`.
- Sub-module `spi_sync2`: a parameterizable-width 2-flop synchronizer, instantiated once with width 3 and reset by `areset`.

## Test plan

- Mode 0, MSB first, `tx_data`=8'hA5 preloaded, master sends 8'h3C:
  - `miso_o` serial pattern is 1,0,1,0,0,1,0,1;
  - `rx_data`=8'h3C and `rx_valid`=1.
- Modes 1, 2 and 3, LSB first, `tx_data`=8'h81, master sends 8'h7E:
  - the correct bits are seen on the correct edges;
  - `rx_data`=8'h7E.
- Two back-to-back words with `cs_n` held low:
  - tx 8'h11 then 8'h22, `rx_ready` tied to 1;
  - two `rx_valid` acceptances; `tx_ready` rises after each load.
- Holding register empty at `cs_n` fall:
  - `miso_o` is all zeros;
  - `underrun_o`=1 (0 with the macro undefined);
  - `err_clr` returns it to 0.
- `rx_ready`=0 across two words, 8'hAA then 8'h55:
  - `rx_data`=8'h55;
  - `overrun_o`=1.
- `cs_n` rising after 5 bits, then a full word 8'hC3:
  - no `rx_valid` after the aborted transfer;
  - the next word gives `rx_data`=8'hC3.
- `areset` asserted mid-word:
  - all outputs return to their reset values at once;
  - the next transfer after a fresh `cs_n` fall is received correctly.
